// File: rtl/arbiter_rr_burst.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_rr_burst
//  Description : Round-robin SDRAM request arbiter. Grants one client at a
//                time, locks the grant for a whole write burst, and routes
//                returned read data to the client whose ID matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_burst #(
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int IDN   = 2,
  parameter int N     = 4,
  parameter int BURST = 8
) (
  input  logic            clkSYS,
  input  logic            n_reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    wr,
  input  logic [N*AN-1:0] addr,
  input  logic [N*DN-1:0] data,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    valid,
  output logic [DN-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [AN-1:0]   mem_addr,
  output logic [DN-1:0]   mem_data,
  output logic [IDN-1:0]  mem_id,
  input  logic            mem_ack,
  input  logic [DN-1:0]   mem_rdata,
  input  logic            mem_valid,
  input  logic [IDN-1:0]  mem_rid
);

  // Burst word counter must be able to hold BURST itself.
  localparam int               c_cnt_w     = $clog2(BURST) + 1;
  localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(BURST - 1);
  localparam logic [IDN-1:0]   c_last_id   = IDN'(N - 1);
  localparam logic [IDN:0]     c_n_ext     = (IDN + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WBURST = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDN-1:0]       r_gnt;
  logic [IDN-1:0]       w_gnt_nxt;
  logic [IDN-1:0]       r_ptr;
  logic [IDN-1:0]       w_ptr_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  logic [IDN-1:0]       w_pick;
  logic                 w_found;
  logic [IDN:0]         w_idx;
  logic [IDN-1:0]       w_gnt_inc;
  logic                 w_req_gnt;
  logic                 w_busy;
  logic                 w_ack_fire;

  logic [AN-1:0]        w_addr_arr [N];
  logic [DN-1:0]        w_data_arr [N];

  // Unpack the per-client buses and build the per-client ack/valid strobes.
  for (genvar i = 0; i < N; i++) begin : g_client
    assign w_addr_arr[i] = addr[i*AN +: AN];
    assign w_data_arr[i] = data[i*DN +: DN];
    assign ack[i]        = w_ack_fire & (r_gnt == IDN'(i));
    assign valid[i]      = mem_valid & (mem_rid == IDN'(i));
  end

  // Round-robin search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (IDN + 1)'(k);
      if (w_idx >= c_n_ext) begin
        w_idx = w_idx - c_n_ext;
      end
      if (!w_found && req[w_idx[IDN-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IDN-1:0];
      end
    end
  end

  // Pointer value after the current grant finishes: one past the winner.
  always_comb begin
    w_gnt_inc = (r_gnt == c_last_id) ? '0 : r_gnt + IDN'(1);
  end

  // Next-state logic: grant selection, read/burst completion and abort.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt = w_pick;
          // wr is only looked at here; later changes do not alter the grant type
          if (wr[w_pick]) begin
            w_state_nxt = S_WBURST;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        if (!w_req_gnt) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_gnt_inc;
          w_cnt_nxt   = '0;
        end else if (mem_ack) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_gnt_inc;
        end
      end
      S_WBURST: begin
        if (!w_req_gnt) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_gnt_inc;
          w_cnt_nxt   = '0;
        end else if (mem_ack) begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last_word) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_gnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Memory-side outputs follow the granted client; gated off in IDLE.
  always_comb begin
    w_req_gnt  = req[r_gnt];
    w_busy     = (r_state != S_IDLE);
    mem_req    = w_busy & w_req_gnt;
    mem_wr     = (r_state == S_WBURST);
    mem_addr   = w_addr_arr[r_gnt];
    mem_data   = w_data_arr[r_gnt];
    mem_id     = r_gnt;
    w_ack_fire = mem_ack & mem_req & w_busy;
    rdata      = mem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_rr_burst
//  Description : Randomised scoreboard bench for arbiter_rr_burst with a
//                grant-owner reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr_burst;

  localparam int AN    = 24;
  localparam int DN    = 16;
  localparam int IDN   = 2;
  localparam int N     = 4;
  localparam int BURST = 8;
  localparam int NCYC  = 4000;

  logic            clkSYS;
  logic            n_reset;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AN-1:0] addr;
  logic [N*DN-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    valid;
  logic [DN-1:0]   rdata;
  logic            mem_req;
  logic            mem_wr;
  logic [AN-1:0]   mem_addr;
  logic [DN-1:0]   mem_data;
  logic [IDN-1:0]  mem_id;
  logic            mem_ack;
  logic [DN-1:0]   mem_rdata;
  logic            mem_valid;
  logic [IDN-1:0]  mem_rid;

  arbiter_rr_burst #(
    .AN(AN), .DN(DN), .IDN(IDN), .N(N), .BURST(BURST)
  ) dut (
    .clkSYS(clkSYS), .n_reset(n_reset), .req(req), .wr(wr), .addr(addr),
    .data(data), .ack(ack), .valid(valid), .rdata(rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_id(mem_id), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_rid(mem_rid)
  );

  initial clkSYS = 1'b0;
  always #5 clkSYS = ~clkSYS;

  typedef struct {
    int            cyc;
    int            id;
    bit            w;
    logic [AN-1:0] a;
    logic [DN-1:0] d;
  } ack_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  v;
    logic [DN-1:0] rd;
  } val_t;

  ack_t ackq[$];
  val_t valq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   chk_en = 1'b0;

  // Reference model: who owns the memory port, how many words remain, and
  // where the next round-robin search starts. -1 means nobody owns it.
  int   m_owner = -1;
  bit   m_write = 1'b0;
  int   m_left  = 0;
  int   m_ptr   = 0;

  logic           exp_mem_req;
  logic           exp_mem_wr;
  logic [IDN-1:0] exp_id;

  // Predict this cycle's outputs from the model and the inputs just driven.
  task automatic model_outputs();
    ack_t ea;
    val_t ev;
    exp_mem_req = (m_owner >= 0) && req[m_owner];
    exp_mem_wr  = (m_owner >= 0) && m_write;
    exp_id      = (m_owner >= 0) ? IDN'(m_owner) : '0;
    if (exp_mem_req && mem_ack) begin
      ea.cyc = cyc;
      ea.id  = m_owner;
      ea.w   = m_write;
      ea.a   = addr[m_owner*AN +: AN];
      ea.d   = data[m_owner*DN +: DN];
      ackq.push_back(ea);
    end
    if (mem_valid && int'(mem_rid) < N) begin
      ev.cyc = cyc;
      ev.v   = '0;
      ev.v[mem_rid] = 1'b1;
      ev.rd  = mem_rdata;
      valq.push_back(ev);
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_next();
    bit found;
    int i;
    if (!n_reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && req[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_write = wr[i];
          m_left  = wr[i] ? BURST : 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (mem_ack) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      addr[i*AN +: AN] = AN'($urandom);
      data[i*DN +: DN] = DN'($urandom);
    end
    mem_rdata = DN'($urandom);
    mem_rid   = IDN'($urandom_range(0, N - 1));
    mem_valid = ($urandom_range(0, 2) == 0);
  endtask

  task automatic random_requests();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        req[i] = ~req[i];
        if (req[i]) wr[i] = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 59) == 0) wr[i] = ~wr[i];
    end
    mem_ack = ($urandom_range(0, 9) < 6);
    n_reset = ($urandom_range(0, 599) != 0);
  endtask

  // Monitor: per-cycle control checks, plus queue pops whenever the DUT
  // presents an ack or valid (or the scoreboard says it should have).
  always @(negedge clkSYS) begin
    ack_t         ea;
    val_t         ev;
    logic [N-1:0] exp_v;
    #2;
    if (chk_en) begin
      checks++;
      if (mem_req !== exp_mem_req) begin
        errors++;
        $display("FAIL mem_req cyc=%0d got=%b want=%b", cyc, mem_req, exp_mem_req);
      end
      checks++;
      if (mem_wr !== exp_mem_wr) begin
        errors++;
        $display("FAIL mem_wr cyc=%0d got=%b want=%b", cyc, mem_wr, exp_mem_wr);
      end
      if (exp_mem_req) begin
        checks++;
        if (mem_id !== exp_id) begin
          errors++;
          $display("FAIL mem_id cyc=%0d got=%0d want=%0d", cyc, mem_id, exp_id);
        end
      end
      if (ack !== '0 || (ackq.size() > 0 && ackq[0].cyc == cyc)) begin
        checks++;
        if (ackq.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected cyc=%0d got=%b want=0000", cyc, ack);
        end else begin
          ea = ackq.pop_front();
          exp_v = '0;
          exp_v[ea.id] = 1'b1;
          if (ea.cyc != cyc || ack !== exp_v || mem_id !== IDN'(ea.id) ||
              mem_wr !== ea.w || mem_addr !== ea.a || mem_data !== ea.d) begin
            errors++;
            $display("FAIL ack_word cyc=%0d got ack=%b id=%0d wr=%b a=%h d=%h want cyc=%0d ack=%b id=%0d wr=%b a=%h d=%h",
                     cyc, ack, mem_id, mem_wr, mem_addr, mem_data,
                     ea.cyc, exp_v, ea.id, ea.w, ea.a, ea.d);
          end
        end
      end
      if (valid !== '0 || (valq.size() > 0 && valq[0].cyc == cyc)) begin
        checks++;
        if (valq.size() == 0) begin
          errors++;
          $display("FAIL valid_unexpected cyc=%0d got=%b want=0000", cyc, valid);
        end else begin
          ev = valq.pop_front();
          if (ev.cyc != cyc || valid !== ev.v || rdata !== ev.rd) begin
            errors++;
            $display("FAIL read_return cyc=%0d got valid=%b rdata=%h want cyc=%0d valid=%b rdata=%h",
                     cyc, valid, rdata, ev.cyc, ev.v, ev.rd);
          end
        end
      end
    end
  end

  // Stimulus: directed phases from the test plan, then randomised traffic.
  initial begin
    n_reset   = 1'b1;
    req       = '0;
    wr        = '0;
    addr      = '0;
    data      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_valid = 1'b0;
    mem_rid   = '0;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clkSYS);
      cyc = c;
      randomize_payload();
      if (c <= 3) begin
        // reset held with every client requesting
        n_reset = 1'b0;
        req     = '1;
        wr      = '0;
        mem_ack = $urandom_range(0, 1) != 0;
        if (c == 1) mem_valid = 1'b0;
      end else if (c <= 30) begin
        // fairness: two readers, memory always ready
        n_reset = 1'b1;
        req     = 4'b0110;
        wr      = '0;
        mem_ack = 1'b1;
      end else if (c <= 34) begin
        req     = '0;
        mem_ack = 1'b1;
      end else if (c <= 70) begin
        // write lock: client 3 bursts while client 0 waits to read
        req     = 4'b1001;
        wr      = 4'b1000;
        mem_ack = 1'b1;
      end else if (c <= 80) begin
        // backpressure on a single read grant, then release
        req     = 4'b0010;
        wr      = '0;
        mem_ack = (c >= 78);
      end else if (c <= 82) begin
        req       = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'hBEEF;
        mem_rid   = (c == 81) ? 2'd2 : 2'd3;
      end else begin
        random_requests();
      end
      if (c >= 2) chk_en = 1'b1;
      model_outputs();
      model_next();
    end
    #3;
    chk_en = 1'b0;
    checks++;
    if (ackq.size() != 0) begin
      errors++;
      $display("FAIL ack_leftover got=%0d pending want=0", ackq.size());
    end
    checks++;
    if (valq.size() != 0) begin
      errors++;
      $display("FAIL valid_leftover got=%0d pending want=0", valq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbiter_rr_burst.md
# arbiter_rr_burst

Round-robin SDRAM request arbiter with write-burst locking, in the `clkSYS` domain between the memory clients (TFT, display, spare ports) and the `sdram` controller request channel. It grants one requester at a time and holds the grant for a whole write burst so that burst words are never interleaved. It returns read data to the requester whose ID matches the memory's return ID. It sits alongside `arbiter_sync_pri` as a fairness-based alternative, so that no single client can starve the others.

## Interface
Parameters:
- `AN`, 24, address width
- `DN`, 16, data width
- `IDN`, 2, requester ID width; `N` ≤ 2^`IDN`
- `N`, 4, number of requesters
- `BURST`, 8, words per write burst; power of two, ≥ 1

Ports:
- `clkSYS` in 1: system clock; one clock, all logic on its rising edge
- `n_reset` in 1: reset, synchronous, active-low
- `req` in N: per-requester request
- `wr` in N: per-requester write flag; meaningful while `req` is high
- `addr` in N*AN: per-requester address, packed, requester i at [i*AN +: AN]
- `data` in N*DN: per-requester write data, packed the same way
- `ack` out N: per-requester acknowledge; a word is accepted in the cycle its `ack` is high
- `valid` out N: per-requester read-data valid
- `rdata` out DN: read data, broadcast to all requesters
- `mem_req` out 1: request to SDRAM
- `mem_wr` out 1: write flag to SDRAM
- `mem_addr` out AN: address to SDRAM
- `mem_data` out DN: write data to SDRAM
- `mem_id` out IDN: index of the granted requester
- `mem_ack` in 1: SDRAM accepted the current word
- `mem_rdata` in DN: read data from SDRAM
- `mem_valid` in 1: read data valid
- `mem_rid` in IDN: ID tag of the returned read data

## Operation
- Registered state:
  - `state` ∈ {IDLE, READ, WBURST}
  - `gnt`: IDN-bit index of the granted requester
  - `ptr`: IDN-bit round-robin priority pointer
  - `cnt`: count of write words acked in the current burst
- IDLE:
  - If no requester has `req` high, stay in IDLE.
  - Otherwise, search indices `ptr`, `ptr+1`, … modulo N and pick the first requester with `req` high. Load its index into `gnt`.
  - Go to WBURST if that requester's `wr` is high (clear `cnt`), else go to READ.
- READ: the grant completes on the first `mem_ack`. Then go to IDLE and set `ptr` = (`gnt`+1) mod N.
- WBURST:
  - Each `mem_ack` increments `cnt`.
  - The grant completes on the ack that brings the count to `BURST`. Then go to IDLE and set `ptr` = (`gnt`+1) mod N.
- Abort: in READ or WBURST, if `req[gnt]` is low, go to IDLE the next cycle, clear `cnt`, and advance `ptr` as for a completed grant.
- Outputs while not IDLE (combinational from `gnt`):
  - `mem_req` = `req[gnt]`
  - `mem_wr` = (`state` == WBURST)
  - `mem_addr` and `mem_data` = the slices of requester `gnt`
  - `mem_id` = `gnt`
- Outputs in IDLE: `mem_req` = 0 and `mem_wr` = 0. `mem_addr`, `mem_data` and `mem_id` are driven from `gnt` but are don't-care.
- `ack[i]` = `mem_ack` & `mem_req` & (`gnt` == i) & (`state` != IDLE). All other `ack` bits are 0.
- Read return is independent of the grant state:
  - `rdata` = `mem_rdata`.
  - `valid[i]` = `mem_valid` & (`mem_rid` == i), for i < N.
  - A `mem_rid` ≥ N asserts no `valid` bit.
- `wr` is sampled only in IDLE. A change of `wr[gnt]` during a grant is ignored.

## Timing
- Reset (`n_reset` low at a clock edge) sets `state`=IDLE, `gnt`=0, `ptr`=0, `cnt`=0. Resulting outputs: `mem_req`=0, `mem_wr`=0, `ack`=0. `valid` and `rdata` still follow the memory return inputs.
- Reset asserted mid-burst: the grant is dropped immediately and no further `ack` is issued. The burst is left partially written; completing it is the requester's responsibility.
- Grant latency: `req` first sampled high in IDLE at edge k → `mem_req` high from cycle k+1.
- Completion edge: the cycle with the final `mem_ack` is followed by one IDLE bubble cycle. The next grant drives `mem_req` two cycles after the completion ack, even if requests are pending.
- `ack` and `valid` are combinational from `mem_ack`, `mem_valid` and `mem_rid`: zero-cycle pass-through.
- Simultaneous `mem_valid` for requester j and `mem_ack` for requester i ≠ j in the same cycle are both delivered.
- `cnt` is log2(BURST)+1 bits wide. It never exceeds `BURST`.
- Round-robin worst-case wait for a requester holding `req`: (N−1) grants.

## Test plan
- Reset: hold `n_reset`=0 for 3 cycles with `req`=4'b1111 → `mem_req`=0 and `ack`=0 throughout. After release, the first grant goes to requester 0.
- Fairness: `req`=4'b0110, all reads, `mem_ack` high every cycle `mem_req` is high:
  - grant sequence is 1, 2, 1, 2
  - `mem_id` matches the grant each time
  - one bubble cycle between grants
- Write lock: requester 3 writes (`wr`=1) while requester 0 requests a read at the same time, `BURST`=8:
  - exactly 8 acks go to requester 3 with `mem_wr`=1 and `mem_id`=3
  - requester 0 gets no `ack` until they finish
  - requester 0 is granted next
- Abort: requester 2 drops `req` after 3 of 8 write acks → `mem_req`=0 the next cycle, the state returns to IDLE, and `ptr`=3.
- Read routing: `mem_valid`=1 with `mem_rid`=2 and `mem_rdata`=16'hBEEF → `valid`=4'b0100 and `rdata`=16'hBEEF. With `mem_rid`=3 → `valid`=4'b1000.
- Backpressure: `mem_ack` is low for 5 cycles during a read grant → `mem_req`, `mem_addr` and `mem_id` are stable over those cycles, and `ack` stays 0 until `mem_ack` goes high.
